multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter ALUC_W, default 4: width of the ALU control code.
REQ-002 Parameter ALUC_SUB, default 4'b0011: ALU code driven for branch compare.
REQ-003 Parameter WAIT_MAX, default 15: maximum cycles a memory request may wait for its ack.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst_n, input, 1: reset; one clock, reset is asynchronous and active-low.
REQ-006 Port op_class, input, 3: decoded class of the IR contents: 0 ALU_R, 1 ALU_I, 2 LOAD, 3 STORE, 4 BRANCH, 5 JUMP, 6 HALT, 7 ILLEGAL.
REQ-007 Port alu_op, input, ALUC_W: ALU code for ALU_R, ALU_I, LOAD and STORE.
REQ-008 Port br_ne, input, 1: branch sense; 0 means taken on z=1, 1 means taken on z=0.
REQ-009 Port z, input, 1: ALU zero flag.
REQ-010 Ports imem_req (output, 1) and imem_ack (input, 1): instruction fetch handshake.
REQ-011 Ports dmem_req (output, 1), dmem_we (output, 1) and dmem_ack (input, 1): data memory handshake.
REQ-012 Port ir_we, output, 1: instruction register load strobe.
REQ-013 Ports pc_we (output, 1) and pc_sel (output, 2): PC update; pc_sel is 0 SEQ, 1 BRANCH, 2 JUMP.
REQ-014 Ports alu_c (output, ALUC_W), alu_src_imm (output, 1) and c_ext16 (output, 1): ALU control.
REQ-015 Ports rf_w (output, 1) and rf_src_mem (output, 1): register file write enable and write-data select.
REQ-016 Ports instr_done (output, 1), halted (output, 1) and fault (output, 1): status outputs.

Function
REQ-017 The controller SHALL be a Moore FSM with states FETCH, DECODE, EXEC, MEM, WB, HALT and FAULT; every output SHALL be derived from the state, the latched class and the current handshake inputs only.
REQ-018 FETCH: imem_req=1. On imem_ack=1, ir_we=1 in that same cycle and the next state is DECODE.
REQ-019 DECODE (1 cycle): latch op_class, alu_op and br_ne. Next state: ILLEGAL->FAULT, HALT->HALT, anything else->EXEC.
REQ-020 EXEC, ALU_R/ALU_I: alu_c=alu_op; alu_src_imm=1 for ALU_I only; next state WB.
REQ-021 EXEC, LOAD/STORE: alu_c=alu_op; alu_src_imm=1; next state MEM.
REQ-022 EXEC, BRANCH: alu_c=ALUC_SUB; pc_we=1. pc_sel=BRANCH when taken (z XOR br_ne = 1), else SEQ. Next state FETCH.
REQ-023 EXEC, JUMP: pc_we=1, pc_sel=JUMP; next state FETCH.
REQ-024 MEM: dmem_req=1 and dmem_we=(class==STORE), both held stable until ack. On dmem_ack: STORE asserts pc_we with SEQ and goes to FETCH; LOAD goes to WB.
REQ-025 WB: rf_w=1; rf_src_mem=(class==LOAD); pc_we=1 with SEQ; next state FETCH.
REQ-026 instr_done SHALL equal pc_we; each retired instruction gives exactly one pulse.
REQ-027 c_ext16 SHALL be 1 except for ALU_I with alu_op bit ALUC_W-1 set (logical ops use zero-extend).
REQ-028 A wait counter SHALL clear on entry to FETCH or MEM and increment each cycle the ack is low. When the count reaches WAIT_MAX with the ack still low, the next state is FAULT.
REQ-029 An ack arriving in the same cycle the count reaches WAIT_MAX SHALL win: normal transition, no fault.
REQ-030 An ack in any state other than the one waiting for it SHALL be ignored.
REQ-031 HALT and FAULT SHALL be terminal until reset; halted=1 in HALT and fault=1 in FAULT; all strobes are 0 in both states.
REQ-032 Minimum latency with same-cycle ack: ALU, branch and jump 3-4 cycles; LOAD 5 cycles; STORE 4 cycles.

Reset
REQ-033 rst_n=0 SHALL asynchronously force state FETCH, clear the wait counter and the latched class, and drive every strobe and status output to 0.
REQ-034 Reset asserted mid-handshake SHALL drop imem_req/dmem_req in the same cycle; no pc_we or rf_w is issued.
REQ-035 The first imem_req SHALL appear in the first clock cycle after rst_n deasserts.

Structure
REQ-036 Package multicycle_ctrl_pkg SHALL hold the state enum, the op_class codes and the pc_sel codes.
REQ-037 The wait counter SHALL be the sub-module ctrl_wait_timer (parameter WAIT_MAX; ports clr, inc, expired).

Verification
REQ-038 ALU_R, alu_op=4'b0010, acks same cycle: imem_req, ir_we, then alu_c=0010, rf_w=1 with pc_we SEQ; instr_done at cycle 4.
REQ-039 BRANCH br_ne=0: with z=1, pc_sel=1; with z=0, pc_sel=0; rf_w=0 and dmem_req=0 throughout.
REQ-040 LOAD with dmem_ack delayed 3 cycles: dmem_req held for 4 cycles with dmem_we=0; then rf_w=1, rf_src_mem=1.
REQ-041 STORE with dmem_ack never asserted, WAIT_MAX=15: fault=1 after 15 MEM cycles; no pc_we; stays in FAULT.
REQ-042 op_class=7 reaches FAULT; op_class=6 reaches HALT with halted=1; rst_n pulse low returns to FETCH with all outputs 0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_pkg
// Shared encodings for the multicycle controller: FSM state enum,
// decoded instruction class codes and PC source select codes.
// No ports (package only).
// ---------------------------------------------------------------------------
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_FAULT  = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        OP_ALU_R   = 3'd0,
        OP_ALU_I   = 3'd1,
        OP_LOAD    = 3'd2,
        OP_STORE   = 3'd3,
        OP_BRANCH  = 3'd4,
        OP_JUMP    = 3'd5,
        OP_HALT    = 3'd6,
        OP_ILLEGAL = 3'd7
    } op_class_e;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2
    } pc_sel_e;

endpackage

// File: rtl/ctrl_wait_timer.sv
// ---------------------------------------------------------------------------
// ctrl_wait_timer
// Counts cycles a handshake has been waiting for its ack.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : return the count to zero (state change in the controller)
//   inc        : the awaited ack is low this cycle
//   expired    : this is the WAIT_MAX-th consecutive cycle without an ack
// ---------------------------------------------------------------------------
module ctrl_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_MAX - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q holds the number of earlier ack-less cycles, so the current
    // ack-less cycle is the WAIT_MAX-th one when cnt_q == WAIT_MAX-1.
    // An ack in that cycle drops inc and therefore suppresses expiry.
    assign expired = inc && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Moore-style control FSM for a multicycle datapath:
// FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH, with terminal HALT and
// FAULT states and a timeout on both memory handshakes.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   op_class, alu_op,
//   br_ne               : decoded instruction fields, sampled in DECODE
//   z                   : ALU zero flag (branch resolution in EXEC)
//   imem_req/imem_ack   : instruction fetch handshake
//   dmem_req/dmem_we/
//   dmem_ack            : data memory handshake
//   ir_we               : instruction register load strobe
//   pc_we, pc_sel       : PC update strobe and source (SEQ/BRANCH/JUMP)
//   alu_c, alu_src_imm,
//   c_ext16             : ALU operation, operand B select, sign-extend
//   rf_w, rf_src_mem    : register write strobe and write-data select
//   instr_done, halted,
//   fault               : status
// ---------------------------------------------------------------------------
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int                ALUC_W   = 4,
    parameter logic [ALUC_W-1:0] ALUC_SUB = ALUC_W'(4'b0011),
    parameter int                WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        op_class,
    input  logic [ALUC_W-1:0] alu_op,
    input  logic              br_ne,
    input  logic              z,
    output logic              imem_req,
    input  logic              imem_ack,
    output logic              dmem_req,
    output logic              dmem_we,
    input  logic              dmem_ack,
    output logic              ir_we,
    output logic              pc_we,
    output logic [1:0]        pc_sel,
    output logic [ALUC_W-1:0] alu_c,
    output logic              alu_src_imm,
    output logic              c_ext16,
    output logic              rf_w,
    output logic              rf_src_mem,
    output logic              instr_done,
    output logic              halted,
    output logic              fault
);

    state_e            state_q, state_d;
    op_class_e         cls_q, cls_d;
    logic [ALUC_W-1:0] alu_op_q, alu_op_d;
    logic              br_ne_q, br_ne_d;

    logic tmr_clr, tmr_inc, tmr_expired;

    // Any state change restarts the wait count, which covers every entry
    // into FETCH and MEM (and leaves it at zero everywhere else).
    assign tmr_clr = (state_d != state_q);

    ctrl_wait_timer #(
        .WAIT_MAX(WAIT_MAX)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmr_clr),
        .inc    (tmr_inc),
        .expired(tmr_expired)
    );

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        cls_d    = cls_q;
        alu_op_d = alu_op_q;
        br_ne_d  = br_ne_q;
        tmr_inc  = 1'b0;

        case (state_q)
            ST_FETCH: begin
                tmr_inc = !imem_ack;
                if (imem_ack) begin
                    state_d = ST_DECODE;
                end else if (tmr_expired) begin
                    state_d = ST_FAULT;
                end
            end

            ST_DECODE: begin
                cls_d    = op_class_e'(op_class);
                alu_op_d = alu_op;
                br_ne_d  = br_ne;
                case (op_class_e'(op_class))
                    OP_ILLEGAL: state_d = ST_FAULT;
                    OP_HALT:    state_d = ST_HALT;
                    default:    state_d = ST_EXEC;
                endcase
            end

            ST_EXEC: begin
                case (cls_q)
                    OP_ALU_R, OP_ALU_I: state_d = ST_WB;
                    OP_LOAD, OP_STORE:  state_d = ST_MEM;
                    default:            state_d = ST_FETCH;
                endcase
            end

            ST_MEM: begin
                tmr_inc = !dmem_ack;
                if (dmem_ack) begin
                    state_d = (cls_q == OP_LOAD) ? ST_WB : ST_FETCH;
                end else if (tmr_expired) begin
                    state_d = ST_FAULT;
                end
            end

            ST_WB:    state_d = ST_FETCH;
            ST_HALT:  state_d = ST_HALT;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_FAULT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_FETCH;
            cls_q    <= OP_ALU_R;
            alu_op_q <= '0;
            br_ne_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cls_q    <= cls_d;
            alu_op_q <= alu_op_d;
            br_ne_q  <= br_ne_d;
        end
    end

    // Output decode from state, latched class and the live handshake inputs
    always_comb begin
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_sel      = PC_SEQ;
        alu_c       = '0;
        alu_src_imm = 1'b0;
        rf_w        = 1'b0;
        rf_src_mem  = 1'b0;
        halted      = 1'b0;
        fault       = 1'b0;
        // Logical immediates (ALU_I with the top opcode bit set) zero-extend.
        c_ext16     = !((cls_q == OP_ALU_I) && alu_op_q[ALUC_W-1]);

        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ack;
            end

            ST_EXEC: begin
                case (cls_q)
                    OP_ALU_R: begin
                        alu_c = alu_op_q;
                    end
                    OP_ALU_I, OP_LOAD, OP_STORE: begin
                        alu_c       = alu_op_q;
                        alu_src_imm = 1'b1;
                    end
                    OP_BRANCH: begin
                        alu_c  = ALUC_SUB;
                        pc_we  = 1'b1;
                        pc_sel = (z ^ br_ne_q) ? PC_BRANCH : PC_SEQ;
                    end
                    OP_JUMP: begin
                        pc_we  = 1'b1;
                        pc_sel = PC_JUMP;
                    end
                    default: ;
                endcase
            end

            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls_q == OP_STORE);
                // A store retires on its ack; a load retires in WB.
                if (dmem_ack && (cls_q == OP_STORE)) begin
                    pc_we = 1'b1;
                end
            end

            ST_WB: begin
                rf_w       = 1'b1;
                rf_src_mem = (cls_q == OP_LOAD);
                pc_we      = 1'b1;
            end

            ST_HALT:  halted = 1'b1;
            ST_FAULT: fault  = 1'b1;
            default: ;
        endcase

        // While reset is held, the state already reads FETCH; mask the
        // outputs so no request or strobe is visible during reset.
        if (!rst_n) begin
            imem_req    = 1'b0;
            dmem_req    = 1'b0;
            dmem_we     = 1'b0;
            ir_we       = 1'b0;
            pc_we       = 1'b0;
            pc_sel      = PC_SEQ;
            alu_c       = '0;
            alu_src_imm = 1'b0;
            c_ext16     = 1'b0;
            rf_w        = 1'b0;
            rf_src_mem  = 1'b0;
            halted      = 1'b0;
            fault       = 1'b0;
        end
    end

    // Every retirement is exactly one PC write.
    assign instr_done = pc_we;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
// Self-checking bench for multicycle_ctrl: a constant vector table, directed
// multi-cycle sequences and randomized instruction streams checked against a
// transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

    localparam int          ALUC_W   = 4;
    localparam logic [3:0]  ALUC_SUB = 4'b0011;
    localparam int          WAIT_MAX = 15;

    logic       clk;
    logic       rst_n;
    logic [2:0] op_class;
    logic [3:0] alu_op;
    logic       br_ne, z;
    logic       imem_req, imem_ack;
    logic       dmem_req, dmem_we, dmem_ack;
    logic       ir_we, pc_we;
    logic [1:0] pc_sel;
    logic [3:0] alu_c;
    logic       alu_src_imm, c_ext16, rf_w, rf_src_mem;
    logic       instr_done, halted, fault;

    multicycle_ctrl #(
        .ALUC_W  (ALUC_W),
        .ALUC_SUB(ALUC_SUB),
        .WAIT_MAX(WAIT_MAX)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_class   (op_class),
        .alu_op     (alu_op),
        .br_ne      (br_ne),
        .z          (z),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ack   (dmem_ack),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_sel     (pc_sel),
        .alu_c      (alu_c),
        .alu_src_imm(alu_src_imm),
        .c_ext16    (c_ext16),
        .rf_w       (rf_w),
        .rf_src_mem (rf_src_mem),
        .instr_done (instr_done),
        .halted     (halted),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic [3:0] alu_c;
        logic       alu_src_imm;
        logic       c_ext16;
        logic       rf_w;
        logic       rf_src_mem;
        logic       instr_done;
        logic       halted;
        logic       fault;
    } outs_t;

    typedef struct {
        logic       rst;
        logic       iack;
        logic       dack;
        logic [2:0] cls;
        logic [3:0] op;
        logic       bn;
        logic       zz;
        outs_t      exp;
    } vec_t;

    vec_t tbl[$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_dreq   = 0;
    int n_pcwe   = 0;

    // Reference model state: the class/opcode of the most recently decoded
    // instruction (reset clears it) determines the extend control.
    logic [2:0] m_cls;
    logic [3:0] m_op;

    function automatic logic m_cext();
        return !((m_cls == 3'd1) && m_op[3]);
    endfunction

    function automatic outs_t sample();
        outs_t s;
        s.imem_req    = imem_req;
        s.dmem_req    = dmem_req;
        s.dmem_we     = dmem_we;
        s.ir_we       = ir_we;
        s.pc_we       = pc_we;
        s.pc_sel      = pc_sel;
        s.alu_c       = alu_c;
        s.alu_src_imm = alu_src_imm;
        s.c_ext16     = c_ext16;
        s.rf_w        = rf_w;
        s.rf_src_mem  = rf_src_mem;
        s.instr_done  = instr_done;
        s.halted      = halted;
        s.fault       = fault;
        return s;
    endfunction

    function automatic outs_t mko(input logic ir, dr, dw, iw, pw,
                                  input logic [1:0] ps, input logic [3:0] ac,
                                  input logic si, ce, rw, rs, hl, ft);
        outs_t o;
        o.imem_req = ir;  o.dmem_req = dr;  o.dmem_we = dw;  o.ir_we = iw;
        o.pc_we = pw;     o.pc_sel = ps;    o.alu_c = ac;    o.alu_src_imm = si;
        o.c_ext16 = ce;   o.rf_w = rw;      o.rf_src_mem = rs;
        o.instr_done = pw; o.halted = hl;   o.fault = ft;
        return o;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(1, 0));
    endfunction

    task automatic add(input logic rst, iack, dack, input logic [2:0] cls,
                       input logic [3:0] op, input logic bn, zz, input outs_t e);
        vec_t v;
        v.rst = rst; v.iack = iack; v.dack = dack; v.cls = cls;
        v.op = op; v.bn = bn; v.zz = zz; v.exp = e;
        tbl.push_back(v);
    endtask

    // Apply one cycle of inputs away from the rising edge, then let the
    // combinational outputs settle before they are sampled.
    task automatic drive(input logic rst, iack, dack, input logic [2:0] cls,
                         input logic [3:0] op, input logic bn, zz);
        @(negedge clk);
        rst_n = rst; imem_ack = iack; dmem_ack = dack;
        op_class = cls; alu_op = op; br_ne = bn; z = zz;
        #1;
        if (dmem_req) n_dreq++;
        if (pc_we) n_pcwe++;
    endtask

    task automatic check(input string name, input outs_t e);
        outs_t a;
        a = sample();
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL %s @%0t: outputs %05h, expected %05h", name, $time, a, e);
    endtask

    task automatic chk_int(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    task automatic do_reset();
        drive(1'b0, rb(), rb(), 3'($urandom_range(7, 0)), 4'($urandom), rb(), rb());
        check("reset", '0);
        m_cls = 3'd0;
        m_op  = 4'd0;
    endtask

    // Runs one instruction from its first FETCH cycle. fdly/mdly are the
    // number of ack-less cycles before the fetch/data ack. dead returns
    // 0 = retired normally, 1 = ended in FAULT, 2 = ended in HALT.
    task automatic run_instr(input logic [2:0] cls, input logic [3:0] op,
                             input logic bn, zz, input int fdly, mdly,
                             output int dead);
        outs_t e;
        logic  ack;
        dead = 0;
        for (int i = 0; i <= fdly; i++) begin
            ack = (i == fdly);
            drive(1'b1, ack, rb(), 3'($urandom_range(7, 0)), 4'($urandom), rb(), rb());
            e = '0; e.imem_req = 1'b1; e.ir_we = ack; e.c_ext16 = m_cext();
            check("fetch", e);
            if (!ack && (i == WAIT_MAX - 1)) begin
                dead = 1;
                return;
            end
        end
        drive(1'b1, rb(), rb(), cls, op, bn, rb());
        e = '0; e.c_ext16 = m_cext();
        check("decode", e);
        m_cls = cls;
        m_op  = op;
        if (cls == 3'd7) begin dead = 1; return; end
        if (cls == 3'd6) begin dead = 2; return; end

        drive(1'b1, rb(), rb(), 3'($urandom_range(7, 0)), 4'($urandom), rb(), zz);
        e = '0; e.c_ext16 = m_cext();
        case (cls)
            3'd0:       e.alu_c = op;
            3'd1, 3'd2,
            3'd3:       begin e.alu_c = op; e.alu_src_imm = 1'b1; end
            3'd4:       begin
                            e.alu_c = ALUC_SUB; e.pc_we = 1'b1;
                            e.pc_sel = (zz != bn) ? 2'd1 : 2'd0;
                        end
            default:    begin e.pc_we = 1'b1; e.pc_sel = 2'd2; end
        endcase
        e.instr_done = e.pc_we;
        check("exec", e);
        if (cls >= 3'd4) return;

        if (cls == 3'd2 || cls == 3'd3) begin
            for (int i = 0; i <= mdly; i++) begin
                ack = (i == mdly);
                drive(1'b1, rb(), ack, 3'($urandom_range(7, 0)), 4'($urandom), rb(), rb());
                e = '0; e.dmem_req = 1'b1; e.dmem_we = (cls == 3'd3);
                e.c_ext16 = m_cext();
                if (ack && cls == 3'd3) begin e.pc_we = 1'b1; e.instr_done = 1'b1; end
                check("mem", e);
                if (!ack && (i == WAIT_MAX - 1)) begin
                    dead = 1;
                    return;
                end
            end
            if (cls == 3'd3) return;
        end

        drive(1'b1, rb(), rb(), 3'($urandom_range(7, 0)), 4'($urandom), rb(), rb());
        e = '0; e.rf_w = 1'b1; e.rf_src_mem = (cls == 3'd2); e.pc_we = 1'b1;
        e.instr_done = 1'b1; e.c_ext16 = m_cext();
        check("wb", e);
    endtask

    task automatic terminal(input int dead, input int n);
        outs_t e;
        for (int i = 0; i < n; i++) begin
            drive(1'b1, rb(), rb(), 3'($urandom_range(7, 0)), 4'($urandom), rb(), rb());
            e = '0; e.c_ext16 = m_cext();
            if (dead == 1) e.fault = 1'b1;
            else e.halted = 1'b1;
            check(dead == 1 ? "fault_hold" : "halt_hold", e);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int dead;
        logic [2:0] rc;
        int fd, md;

        rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        op_class = '0; alu_op = '0; br_ne = 1'b0; z = 1'b0;
        m_cls = '0; m_op = '0;

        // rst iack dack cls op bn z | ir dr dw iw pw ps ac si ce rw rs hl ft
        add(0,0,0,0,0,0,0, mko(0,0,0,0,0,0,0,0,0,0,0,0,0));
        add(0,1,1,0,0,0,0, mko(0,0,0,0,0,0,0,0,0,0,0,0,0));
        // ALU_R op 0010, acks same cycle; spurious dmem_ack ignored
        add(1,1,1,0,0,0,0, mko(1,0,0,1,0,0,0,0,1,0,0,0,0));
        add(1,0,1,0,4'b0010,0,0, mko(0,0,0,0,0,0,0,0,1,0,0,0,0));
        add(1,1,1,7,0,0,0, mko(0,0,0,0,0,0,4'b0010,0,1,0,0,0,0));
        add(1,1,1,7,0,0,0, mko(0,0,0,0,1,0,0,0,1,1,0,0,0));
        // BRANCH br_ne=0, z=1 taken
        add(1,1,0,0,0,0,0, mko(1,0,0,1,0,0,0,0,1,0,0,0,0));
        add(1,0,0,4,0,0,0, mko(0,0,0,0,0,0,0,0,1,0,0,0,0));
        add(1,0,0,0,0,0,1, mko(0,0,0,0,1,1,ALUC_SUB,0,1,0,0,0,0));
        // BRANCH br_ne=0, z=0 not taken
        add(1,1,0,0,0,0,0, mko(1,0,0,1,0,0,0,0,1,0,0,0,0));
        add(1,0,0,4,0,0,1, mko(0,0,0,0,0,0,0,0,1,0,0,0,0));
        add(1,0,0,0,0,0,0, mko(0,0,0,0,1,0,ALUC_SUB,0,1,0,0,0,0));
        // BRANCH br_ne=1, z=0 taken
        add(1,1,0,0,0,0,0, mko(1,0,0,1,0,0,0,0,1,0,0,0,0));
        add(1,0,0,4,0,1,0, mko(0,0,0,0,0,0,0,0,1,0,0,0,0));
        add(1,0,0,0,0,0,0, mko(0,0,0,0,1,1,ALUC_SUB,0,1,0,0,0,0));
        // JUMP after one-cycle fetch wait
        add(1,0,1,0,0,0,0, mko(1,0,0,0,0,0,0,0,1,0,0,0,0));
        add(1,1,0,0,0,0,0, mko(1,0,0,1,0,0,0,0,1,0,0,0,0));
        add(1,0,0,5,0,0,0, mko(0,0,0,0,0,0,0,0,1,0,0,0,0));
        add(1,0,0,0,0,0,0, mko(0,0,0,0,1,2,0,0,1,0,0,0,0));
        // ALU_I logical op 1001: zero-extend until the next decode
        add(1,1,0,0,0,0,0, mko(1,0,0,1,0,0,0,0,1,0,0,0,0));
        add(1,0,0,1,4'b1001,0,0, mko(0,0,0,0,0,0,0,0,1,0,0,0,0));
        add(1,0,0,0,0,0,0, mko(0,0,0,0,0,0,4'b1001,1,0,0,0,0,0));
        add(1,0,0,0,0,0,0, mko(0,0,0,0,1,0,0,0,0,1,0,0,0));
        add(1,0,0,0,0,0,0, mko(1,0,0,0,0,0,0,0,0,0,0,0,0));
        add(1,1,0,0,0,0,0, mko(1,0,0,1,0,0,0,0,0,0,0,0,0));
        // HALT is terminal; acks ignored
        add(1,0,0,6,0,0,0, mko(0,0,0,0,0,0,0,0,0,0,0,0,0));
        add(1,1,1,0,0,0,0, mko(0,0,0,0,0,0,0,0,1,0,0,0,1'b0) | 18'h2);
        add(1,1,1,0,0,0,0, mko(0,0,0,0,0,0,0,0,1,0,0,1,0));
        // reset, then reset again while a fetch is pending
        add(0,0,0,0,0,0,0, mko(0,0,0,0,0,0,0,0,0,0,0,0,0));
        add(1,0,0,0,0,0,0, mko(1,0,0,0,0,0,0,0,1,0,0,0,0));
        add(0,1,0,0,0,0,0, mko(0,0,0,0,0,0,0,0,0,0,0,0,0));
        // ILLEGAL goes to FAULT and stays there
        add(1,1,0,0,0,0,0, mko(1,0,0,1,0,0,0,0,1,0,0,0,0));
        add(1,0,0,7,0,0,0, mko(0,0,0,0,0,0,0,0,1,0,0,0,0));
        add(1,1,1,0,0,0,0, mko(0,0,0,0,0,0,0,0,1,0,0,0,1));
        add(0,0,0,0,0,0,0, mko(0,0,0,0,0,0,0,0,0,0,0,0,0));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].iack, tbl[i].dack, tbl[i].cls,
                  tbl[i].op, tbl[i].bn, tbl[i].zz);
            check($sformatf("tbl[%0d]", i), tbl[i].exp);
        end

        // LOAD with the data ack three cycles late
        do_reset();
        n_dreq = 0;
        run_instr(3'd2, 4'b0101, 1'b0, 1'b0, 0, 3, dead);
        chk_int("load_dmem_req_cycles", n_dreq, 4);

        // STORE never acked: FAULT after WAIT_MAX MEM cycles, no PC write
        do_reset();
        n_dreq = 0; n_pcwe = 0;
        run_instr(3'd3, 4'b0001, 1'b0, 1'b0, 0, 1000, dead);
        terminal(1, 4);
        chk_int("store_timeout_mem_cycles", n_dreq, WAIT_MAX);
        chk_int("store_timeout_pc_we", n_pcwe, 0);

        // Acks on the last allowed cycle win, for both handshakes
        do_reset();
        n_pcwe = 0;
        run_instr(3'd3, 4'b0110, 1'b0, 1'b0, WAIT_MAX - 1, WAIT_MAX - 1, dead);
        run_instr(3'd2, 4'b0110, 1'b0, 1'b0, 0, WAIT_MAX - 1, dead);
        chk_int("boundary_retired", n_pcwe, 2);

        // Fetch ack missing for WAIT_MAX cycles
        run_instr(3'd0, 4'b0000, 1'b0, 1'b0, WAIT_MAX, 0, dead);
        terminal(1, 3);

        // Reset in the middle of a data handshake
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 3'd3, 4'd2, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 1'b0);
        check("mem_before_reset", mko(0,1,1,0,0,0,0,0,1,0,0,0,0));
        drive(1'b0, 1'b0, 1'b1, 3'd0, 4'd0, 1'b0, 1'b0);
        check("reset_mid_mem", '0);
        m_cls = 3'd0; m_op = 4'd0;
        run_instr(3'd0, 4'b0111, 1'b0, 1'b0, 0, 0, dead);

        // Randomized instruction stream
        do_reset();
        for (int k = 0; k < 250; k++) begin
            rc = 3'($urandom_range(7, 0));
            fd = ($urandom_range(9, 0) == 0) ? int'($urandom_range(16, 12))
                                             : int'($urandom_range(3, 0));
            md = ($urandom_range(9, 0) == 0) ? int'($urandom_range(16, 12))
                                             : int'($urandom_range(4, 0));
            run_instr(rc, 4'($urandom), rb(), rb(), fd, md, dead);
            if (dead != 0) begin
                terminal(dead, 2);
                do_reset();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
